// File: rtl/onewire_master_if.sv
// Command/response and pad-side signals of the 1-Wire bit engine.
// The master modport is the engine's view. The slave modport is the wrapper/pad view.
interface onewire_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic       rsp_valid;
    logic       rsp_data;
    logic       busy;
    logic       pad_t;
    logic       pad_i;
    logic       pad_o;

    modport master (
        input  cmd_valid, cmd_op, pad_o,
        output cmd_ready, rsp_valid, rsp_data, busy, pad_t, pad_i
    );

    modport slave (
        output cmd_valid, cmd_op, pad_o,
        input  cmd_ready, rsp_valid, rsp_data, busy, pad_t, pad_i
    );
endinterface

// File: rtl/onewire_master.sv
// Standard-speed 1-Wire slot generator: reset/presence, write-0, write-1 and read-bit
// on an open-drain pad. Only the pad tristate control (pad_t) is ever toggled.
module onewire_master #(
    parameter int US_CYCLES   = 50,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rstn,
    onewire_master_if.master        bus
);

    localparam int PW = (US_CYCLES > 1) ? $clog2(US_CYCLES) : 1;

    localparam logic [1:0] OP_RESET  = 2'b00;
    localparam logic [1:0] OP_WRITE0 = 2'b01;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOW     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                 state_q;
    logic [1:0]             op_q;
    logic [PW-1:0]          presc_q;
    logic [PW-1:0]          presc_d;
    logic [9:0]             t_q;
    logic [9:0]             t_d;
    logic                   us_tick;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   bus_s;
    logic                   sample_q;
    logic                   pad_t_q;
    logic                   cmd_ready_q;
    logic                   busy_q;
    logic                   rsp_valid_q;
    logic                   rsp_data_q;
    logic [9:0]             t_low;
    logic [9:0]             t_samp;
    logic [9:0]             t_end;

    assign bus_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        us_tick = (presc_q == PW'(US_CYCLES - 1));
        presc_d = us_tick ? '0 : presc_q + PW'(1);
        t_d     = us_tick ? t_q + 10'd1 : t_q;
    end

    // Slot timing in microseconds for the latched opcode.
    always_comb begin
        t_low  = 10'd6;
        t_samp = 10'd15;
        t_end  = 10'd75;
        case (op_q)
            OP_RESET: begin
                t_low  = 10'd480;
                t_samp = 10'd550;
                t_end  = 10'd960;
            end
            OP_WRITE0: t_low = 10'd60;
            default:   t_low = 10'd6;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            op_q        <= 2'b00;
            presc_q     <= '0;
            t_q         <= '0;
            sync_q      <= '0;
            sample_q    <= 1'b0;
            pad_t_q     <= 1'b1;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], bus.pad_o};
            rsp_valid_q <= 1'b0;

            // Write-0 samples while still in LOW, so sampling is state-independent.
            if (state_q != IDLE && us_tick && t_d == t_samp) begin
                sample_q <= bus_s;
            end

            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid && cmd_ready_q) begin
                        op_q        <= bus.cmd_op;
                        presc_q     <= '0;
                        t_q         <= '0;
                        pad_t_q     <= 1'b0;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= LOW;
                    end else begin
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                LOW: begin
                    presc_q <= presc_d;
                    t_q     <= t_d;
                    if (us_tick && t_d == t_low) begin
                        pad_t_q <= 1'b1;
                        state_q <= RELEASE;
                    end
                end
                RELEASE: begin
                    presc_q <= presc_d;
                    t_q     <= t_d;
                    // Ready is withheld during the rsp_valid cycle and comes back from IDLE.
                    if (us_tick && t_d == t_end) begin
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= (op_q == OP_RESET) ? ~sample_q : sample_q;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    pad_t_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.pad_t     = pad_t_q;
    assign bus.pad_i     = 1'b0;
    assign bus.cmd_ready = cmd_ready_q;
    assign bus.busy      = busy_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_onewire_master.sv
// Directed vector bench for onewire_master with a wired-AND slave model on the pad.
module tb_onewire_master;

    localparam int US = 4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic slaveLow = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    onewire_master_if bus();

    assign bus.pad_o = bus.pad_t & ~slaveLow;

    onewire_master #(.US_CYCLES(US), .SYNC_STAGES(2)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.master)
    );

    typedef struct {
        logic [1:0] op;
        int         loStart;
        int         loEnd;
        int         expLow;
        int         expSlot;
        logic       expRsp;
    } vec_t;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Issues one op at the current negedge; the slave pulls low for cycles [loStart*US, loEnd*US).
    task automatic applyStimulus(input logic [1:0] op, input int loStart, input int loEnd,
                                 input bit hold, output int lowCnt, output int slotCnt,
                                 output int rsp, output int busyErr, output int readyCnt);
        lowCnt   = 0;
        slotCnt  = -1;
        rsp      = -1;
        busyErr  = 0;
        readyCnt = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        @(posedge clk);
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (k == 0 && !hold) bus.cmd_valid = 1'b0;
            if (hold) bus.cmd_op = 2'(k / 7);
            slaveLow = (k >= loStart * US) && (k < loEnd * US);
            if (bus.pad_t === 1'b0) lowCnt++;
            if (bus.busy === bus.cmd_ready) busyErr++;
            if (bus.cmd_ready === 1'b1) readyCnt++;
            if (bus.rsp_valid === 1'b1) begin
                slotCnt = k;
                rsp     = int'(bus.rsp_data);
                break;
            end
        end
        bus.cmd_valid = 1'b0;
        slaveLow      = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[7];
        int lowCnt, slotCnt, rsp, busyErr, readyCnt, rspSeen;

        vecs[0] = '{2'b00, 500, 620, 1920, 3840, 1'b1};
        vecs[1] = '{2'b00,   0,   0, 1920, 3840, 1'b0};
        vecs[2] = '{2'b10,   0,   0,   24,  300, 1'b1};
        vecs[3] = '{2'b01,   0,   0,  240,  300, 1'b0};
        vecs[4] = '{2'b11,   6,  30,   24,  300, 1'b0};
        vecs[5] = '{2'b11,   0,   0,   24,  300, 1'b1};
        vecs[6] = '{2'b10,   6,  30,   24,  300, 1'b0};

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        repeat (3) @(negedge clk);
        checkOutput("reset pad_t",     int'(bus.pad_t),     1);
        checkOutput("reset pad_i",     int'(bus.pad_i),     0);
        checkOutput("reset cmd_ready", int'(bus.cmd_ready), 1);
        checkOutput("reset busy",      int'(bus.busy),      0);
        checkOutput("reset rsp_valid", int'(bus.rsp_valid), 0);
        checkOutput("reset rsp_data",  int'(bus.rsp_data),  0);
        rstn = 1'b1;
        @(negedge clk);

        // Each vector starts on the cycle after the previous rsp_valid, so 2->3 is back-to-back.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].op, vecs[i].loStart, vecs[i].loEnd, 1'b0,
                          lowCnt, slotCnt, rsp, busyErr, readyCnt);
            checkOutput($sformatf("vec%0d low cycles", i), lowCnt, vecs[i].expLow);
            checkOutput($sformatf("vec%0d slot cycles", i), slotCnt, vecs[i].expSlot);
            checkOutput($sformatf("vec%0d rsp_data", i), rsp, int'(vecs[i].expRsp));
            checkOutput($sformatf("vec%0d busy vs ready", i), busyErr, 0);
            @(negedge clk);
            checkOutput($sformatf("vec%0d ready after rsp", i), int'(bus.cmd_ready), 1);
            checkOutput($sformatf("vec%0d rsp_valid pulse", i), int'(bus.rsp_valid), 0);
        end

        // cmd_valid held with a wandering cmd_op: only the first op (read) may run.
        applyStimulus(2'b11, 0, 0, 1'b1, lowCnt, slotCnt, rsp, busyErr, readyCnt);
        checkOutput("hold low cycles", lowCnt, 24);
        checkOutput("hold slot cycles", slotCnt, 300);
        checkOutput("hold rsp_data", rsp, 1);
        checkOutput("hold ready during slot", readyCnt, 0);
        @(negedge clk);
        checkOutput("hold ready after rsp", int'(bus.cmd_ready), 1);
        @(negedge clk);
        checkOutput("hold no extra accept", int'(bus.busy), 0);

        // Abort a reset op at t=200us.
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b00;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (800) @(negedge clk);
        checkOutput("abort pad_t before", int'(bus.pad_t), 0);
        rstn = 1'b0;
        #1;
        checkOutput("abort pad_t async", int'(bus.pad_t), 1);
        checkOutput("abort ready async", int'(bus.cmd_ready), 1);
        checkOutput("abort busy async", int'(bus.busy), 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        rspSeen = 0;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) rspSeen++;
        end
        checkOutput("abort no rsp", rspSeen, 0);
        checkOutput("abort ready idle", int'(bus.cmd_ready), 1);
        applyStimulus(2'b11, 0, 0, 1'b0, lowCnt, slotCnt, rsp, busyErr, readyCnt);
        checkOutput("post-abort low cycles", lowCnt, 24);
        checkOutput("post-abort slot cycles", slotCnt, 300);
        checkOutput("post-abort rsp_data", rsp, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
